alu_ctrl_seq: RTL and testbench

- Registered, parametrised successor to the combinational ALU control decoder in the EX stage.
- Decodes ALUOp/funct into the ALU control code, registers it for one cycle, and sequences multi-cycle MUL operations.
- While a MUL is in flight it drives a stall back to the hazard unit.
- Flags unrecognised R-type funct codes instead of holding the stale output.

---
 rtl/alu_ctrl_pkg.sv | 34 +++
 rtl/alu_ctrl_dec.sv | 40 ++++
 rtl/alu_ctrl_seq.sv | 131 +++++++++++++
 tb/tb_alu_ctrl_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU control decoder: ALUOp values, control codes,
// R-type funct patterns and FSM states.
package alu_ctrl_pkg;

   localparam logic [1:0] ALUOP_LS = 2'b00;
   localparam logic [1:0] ALUOP_BR = 2'b01;
   localparam logic [1:0] ALUOP_R  = 2'b10;
   localparam logic [1:0] ALUOP_I  = 2'b11;

   localparam logic [3:0] CTRL_AND  = 4'b0000;
   localparam logic [3:0] CTRL_XOR  = 4'b0001;
   localparam logic [3:0] CTRL_SLL  = 4'b0010;
   localparam logic [3:0] CTRL_ADD  = 4'b0011;
   localparam logic [3:0] CTRL_SUB  = 4'b0100;
   localparam logic [3:0] CTRL_MUL  = 4'b0101;
   localparam logic [3:0] CTRL_ADDI = 4'b0110;
   localparam logic [3:0] CTRL_SRAI = 4'b0111;
   localparam logic [3:0] CTRL_LS   = 4'b1000;
   localparam logic [3:0] CTRL_BEQ  = 4'b1001;

   // {funct7, funct3}
   localparam logic [9:0] FUNCT_AND = 10'b0000000111;
   localparam logic [9:0] FUNCT_XOR = 10'b0000000100;
   localparam logic [9:0] FUNCT_SLL = 10'b0000000001;
   localparam logic [9:0] FUNCT_ADD = 10'b0000000000;
   localparam logic [9:0] FUNCT_SUB = 10'b0100000000;
   localparam logic [9:0] FUNCT_MUL = 10'b0000001000;

   typedef enum logic {
      StIdle,
      StMulWait
   } state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Pure combinational ALUOp/funct decode: control code, mul flag and illegal R-type flag.
module alu_ctrl_dec #(
   parameter int unsigned FUNCT_W = 10,
   parameter int unsigned CTRL_W  = 4
) (
   input  logic [FUNCT_W-1:0] funct_i,
   input  logic [1:0]         alu_op_i,
   output logic [CTRL_W-1:0]  code_o,
   output logic               is_mul_o,
   output logic               illegal_o
);
   import alu_ctrl_pkg::*;

   always_comb begin
      code_o    = CTRL_W'(CTRL_ADD);
      is_mul_o  = 1'b0;
      illegal_o = 1'b0;
      unique case (alu_op_i)
         ALUOP_LS: code_o = CTRL_W'(CTRL_LS);
         ALUOP_BR: code_o = CTRL_W'(CTRL_BEQ);
         ALUOP_I:  code_o = funct_i[0] ? CTRL_W'(CTRL_SRAI) : CTRL_W'(CTRL_ADDI);
         ALUOP_R: begin
            case (funct_i)
               FUNCT_W'(FUNCT_AND): code_o = CTRL_W'(CTRL_AND);
               FUNCT_W'(FUNCT_XOR): code_o = CTRL_W'(CTRL_XOR);
               FUNCT_W'(FUNCT_SLL): code_o = CTRL_W'(CTRL_SLL);
               FUNCT_W'(FUNCT_ADD): code_o = CTRL_W'(CTRL_ADD);
               FUNCT_W'(FUNCT_SUB): code_o = CTRL_W'(CTRL_SUB);
               FUNCT_W'(FUNCT_MUL): begin
                  code_o   = CTRL_W'(CTRL_MUL);
                  is_mul_o = 1'b1;
               end
               // Unknown funct still issues as add so the ALU sees a defined code.
               default: illegal_o = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decode with multi-cycle MUL sequencing and stall generation.
// Optional perf counters are built when ALU_CTRL_PERF_EN is defined.
module alu_ctrl_seq #(
   parameter int unsigned FUNCT_W = 10,
   parameter int unsigned CTRL_W  = 4,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   input  logic               flush_i,
   input  logic [FUNCT_W-1:0] funct_i,
   input  logic [1:0]         ALUOp_i,
   output logic [CTRL_W-1:0]  ALUCtrl_o,
   output logic               valid_o,
   output logic               busy_o,
`ifdef ALU_CTRL_PERF_EN
   output logic [31:0]        mul_stall_cnt_o,
   output logic [15:0]        illegal_cnt_o,
`endif
   output logic               illegal_o
);
   import alu_ctrl_pkg::*;

   localparam logic [3:0] MulCntInit = 4'(MUL_LAT - 1);
   localparam bit         MulMulti   = (MUL_LAT > 1);

   logic [CTRL_W-1:0] dec_code;
   logic              dec_is_mul;
   logic              dec_illegal;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              illegal_q, illegal_d;

   alu_ctrl_dec #(
      .FUNCT_W (FUNCT_W),
      .CTRL_W  (CTRL_W)
   ) u_dec (
      .funct_i   (funct_i),
      .alu_op_i  (ALUOp_i),
      .code_o    (dec_code),
      .is_mul_o  (dec_is_mul),
      .illegal_o (dec_illegal)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ctrl_d    = ctrl_q;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      illegal_d = 1'b0;
      if (flush_i) begin
         state_d = StIdle;
         cnt_d   = 4'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (valid_i) begin
                  ctrl_d    = dec_code;
                  valid_d   = 1'b1;
                  illegal_d = dec_illegal;
                  if (dec_is_mul && MulMulti) begin
                     state_d = StMulWait;
                     cnt_d   = MulCntInit;
                     busy_d  = 1'b1;
                  end
               end
            end
            StMulWait: begin
               // Upstream is stalled, so valid_i carries nothing meaningful here.
               ctrl_d  = CTRL_W'(CTRL_MUL);
               valid_d = 1'b1;
               if (cnt_q <= 4'd1) begin
                  state_d = StIdle;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d  = cnt_q - 4'd1;
                  busy_d = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         ctrl_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ctrl_q    <= ctrl_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         illegal_q <= illegal_d;
      end
   end

   assign ALUCtrl_o = ctrl_q;
   assign valid_o   = valid_q;
   assign busy_o    = busy_q;
   assign illegal_o = illegal_q;

`ifdef ALU_CTRL_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [15:0] ill_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         ill_cnt_q   <= '0;
      end else begin
         if (busy_q && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (illegal_q && (ill_cnt_q != '1)) ill_cnt_q <= ill_cnt_q + 16'd1;
      end
   end

   assign mul_stall_cnt_o = stall_cnt_q;
   assign illegal_cnt_o   = ill_cnt_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: random and directed decode traffic, MUL stalls,
// flushes and asynchronous reset, checked against a table-driven reference model.
module tb_alu_ctrl_seq;

   localparam int unsigned FUNCT_W = 10;
   localparam int unsigned CTRL_W  = 4;
   localparam int unsigned MUL_LAT = 3;

   typedef struct {
      logic [3:0] code;
      logic       ill;
      logic       busy;
   } exp_t;

   typedef struct {
      logic [9:0] funct;
      logic [3:0] code;
   } rrow_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               valid_i = 1'b0;
   logic               flush_i = 1'b0;
   logic [FUNCT_W-1:0] funct_i = '0;
   logic [1:0]         ALUOp_i = 2'b00;
   logic [CTRL_W-1:0]  ALUCtrl_o;
   logic               valid_o;
   logic               busy_o;
   logic               illegal_o;
`ifdef ALU_CTRL_PERF_EN
   logic [31:0]        mul_stall_cnt_o;
   logic [15:0]        illegal_cnt_o;
`endif

   alu_ctrl_seq #(
      .FUNCT_W (FUNCT_W),
      .CTRL_W  (CTRL_W),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .valid_i         (valid_i),
      .flush_i         (flush_i),
      .funct_i         (funct_i),
      .ALUOp_i         (ALUOp_i),
      .ALUCtrl_o       (ALUCtrl_o),
      .valid_o         (valid_o),
      .busy_o          (busy_o),
`ifdef ALU_CTRL_PERF_EN
      .mul_stall_cnt_o (mul_stall_cnt_o),
      .illegal_cnt_o   (illegal_cnt_o),
`endif
      .illegal_o       (illegal_o)
   );

   always #5 clk = ~clk;

   exp_t       sb[$];
   rrow_t      rtab[6];
   int         n_checks = 0;
   int         n_fail = 0;
   int         stall_left = 0;
   logic [3:0] last_code = 4'd0;
   bit         mon_en = 1'b0;
   int         busy_seen = 0;
   int         ill_seen = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference decode straight from the opcode table.
   task automatic ref_decode(input logic [1:0] op, input logic [9:0] fn,
                             output logic [3:0] code, output logic ill, output logic mul);
      code = 4'b0011;
      ill  = 1'b1;
      mul  = 1'b0;
      if (op == 2'b00) begin code = 4'b1000; ill = 1'b0; end
      else if (op == 2'b01) begin code = 4'b1001; ill = 1'b0; end
      else if (op == 2'b11) begin code = fn[0] ? 4'b0111 : 4'b0110; ill = 1'b0; end
      else begin
         foreach (rtab[i]) if (rtab[i].funct == fn) begin
            code = rtab[i].code;
            ill  = 1'b0;
         end
         mul = (code == 4'b0101) && !ill;
      end
   endtask

   // Drive one cycle; the model advances at the clock edge that samples the inputs.
   task automatic drive(input logic v, input logic fl, input logic [1:0] op,
                        input logic [9:0] fn);
      logic [3:0] code;
      logic       ill, mul;
      exp_t       e;
      valid_i = v;
      flush_i = fl;
      ALUOp_i = op;
      funct_i = fn;
      @(posedge clk);
      if (fl) begin
         sb.delete();
         stall_left = 0;
      end else if (stall_left > 0) begin
         stall_left--;
      end else if (v) begin
         ref_decode(op, fn, code, ill, mul);
         last_code = code;
         if (mul && MUL_LAT > 1) begin
            for (int k = 0; k < int'(MUL_LAT); k++) begin
               e.code = code;
               e.ill  = 1'b0;
               e.busy = (k < int'(MUL_LAT) - 1);
               sb.push_back(e);
            end
            stall_left = MUL_LAT - 1;
         end else begin
            e.code = code;
            e.ill  = ill;
            e.busy = 1'b0;
            sb.push_back(e);
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, 10'd0);
   endtask

   task automatic model_clear();
      sb.delete();
      stall_left = 0;
      last_code = 4'd0;
      busy_seen = 0;
      ill_seen = 0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && !rst) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("valid_o", 32'(valid_o), 32'd1);
            chk("ALUCtrl_o", 32'(ALUCtrl_o), 32'(e.code));
            chk("illegal_o", 32'(illegal_o), 32'(e.ill));
            chk("busy_o", 32'(busy_o), 32'(e.busy));
            if (e.busy) busy_seen++;
            if (e.ill) ill_seen++;
         end else begin
            chk("idle_valid_o", 32'(valid_o), 32'd0);
            chk("idle_busy_o", 32'(busy_o), 32'd0);
            chk("idle_illegal_o", 32'(illegal_o), 32'd0);
            chk("hold_ALUCtrl_o", 32'(ALUCtrl_o), 32'(last_code));
         end
      end
   end

   initial begin
      logic [9:0] fn;
      logic [1:0] op;
      rtab[0] = '{10'b0000000111, 4'b0000};
      rtab[1] = '{10'b0000000100, 4'b0001};
      rtab[2] = '{10'b0000000001, 4'b0010};
      rtab[3] = '{10'b0000000000, 4'b0011};
      rtab[4] = '{10'b0100000000, 4'b0100};
      rtab[5] = '{10'b0000001000, 4'b0101};

      #1;
      chk("rst_ALUCtrl_o", 32'(ALUCtrl_o), 32'd0);
      chk("rst_valid_o", 32'(valid_o), 32'd0);
      chk("rst_busy_o", 32'(busy_o), 32'd0);
      chk("rst_illegal_o", 32'(illegal_o), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      model_clear();
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // Every legal combination, back to back.
      drive(1'b1, 1'b0, 2'b00, 10'h155);
      drive(1'b1, 1'b0, 2'b01, 10'h2aa);
      drive(1'b1, 1'b0, 2'b11, 10'h3fe);
      drive(1'b1, 1'b0, 2'b11, 10'h001);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 2'b10, rtab[i].funct);
      // Illegal funct, then MUL with an add issued on the first free cycle.
      drive(1'b1, 1'b0, 2'b10, 10'b1111111111);
      idle(2);
      drive(1'b1, 1'b0, 2'b10, 10'b0000001000);
      while (stall_left > 0) drive(1'b1, 1'b0, 2'b10, 10'b0100000000);
      drive(1'b1, 1'b0, 2'b10, 10'b0000000000);
      idle(2);
      // Flush in the second MUL cycle, then a normal op.
      drive(1'b1, 1'b0, 2'b10, 10'b0000001000);
      drive(1'b0, 1'b0, 2'b00, 10'd0);
      drive(1'b0, 1'b1, 2'b00, 10'd0);
      drive(1'b1, 1'b0, 2'b11, 10'd0);
      // Flush wins over a simultaneous request.
      drive(1'b1, 1'b1, 2'b01, 10'd0);
      idle(2);

      for (int i = 0; i < 500; i++) begin
         op = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) fn = rtab[$urandom_range(0, 5)].funct;
         else fn = 10'($urandom);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, op, fn);
      end
      idle(MUL_LAT + 2);

`ifdef ALU_CTRL_PERF_EN
      chk("mul_stall_cnt_o", mul_stall_cnt_o, 32'(busy_seen));
      chk("illegal_cnt_o", 32'(illegal_cnt_o), 32'(ill_seen));
`endif

      // Asynchronous reset between clock edges while a MUL is stalling.
      drive(1'b1, 1'b0, 2'b10, 10'b0000001000);
      chk("pre_rst_busy_o", 32'(busy_o), (MUL_LAT > 1) ? 32'd1 : 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("arst_busy_o", 32'(busy_o), 32'd0);
      chk("arst_valid_o", 32'(valid_o), 32'd0);
      chk("arst_ALUCtrl_o", 32'(ALUCtrl_o), 32'd0);
      chk("arst_illegal_o", 32'(illegal_o), 32'd0);
      valid_i = 1'b0;
      model_clear();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      drive(1'b1, 1'b0, 2'b10, 10'b1111111111);
      idle(3);
`ifdef ALU_CTRL_PERF_EN
      chk("illegal_cnt_after_rst", 32'(illegal_cnt_o), 32'd1);
`endif

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
